// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, funct and ALU encodings for the MIPS execute slice
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] J      = 6'b000010;
    localparam logic [5:0] NOOP   = 6'b111111;

    localparam logic [5:0] FUNCT_ADD      = 6'b100000;
    localparam logic [5:0] FUNCT_SUBTRACT = 6'b100010;
    localparam logic [5:0] FUNCT_AND      = 6'b100100;
    localparam logic [5:0] FUNCT_OR       = 6'b100101;
    localparam logic [5:0] FUNCT_SLT      = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational 32-bit ALU with zero flag
module mips_alu
    import mips_pkg::*;
(
    input  logic [2:0]  i_ctrl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_zero
);

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_ANDN: o_result = i_a & ~i_b;
            ALU_ORN:  o_result = i_a | ~i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            default:  o_result = '0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_exec_unit.sv
// rtl/mips_exec_unit.sv - single-cycle MIPS decode, ALU and data-memory slice
module mips_exec_unit
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] Instr,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    output logic        Jump,
    output logic        Branch,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic [2:0]  ALUControl,
    output logic [31:0] SignImm,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic [31:0] ReadData,
    output logic [31:0] Result
);

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    alu_op_e           w_alu_op;
    logic              w_funct_ok;
    logic              w_reg_write_op;
    logic [31:0]       w_src_b;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused;
    logic [31:0]       r_mem [DEPTH];

    assign w_op     = Instr[31:26];
    assign w_funct  = Instr[5:0];
    assign SignImm  = sign_ext16(Instr[15:0]);
    assign w_unused = &{1'b0, Instr[25:16]};

    always_comb begin
        w_reg_write_op = 1'b0;
        RegDst         = 1'b0;
        ALUSrc         = 1'b0;
        Branch         = 1'b0;
        MemWrite       = 1'b0;
        MemToReg       = 1'b0;
        Jump           = 1'b0;
        w_alu_op       = ALUOP_ADD;
        case (w_op)
            R_TYPE: begin w_reg_write_op = 1'b1; RegDst = 1'b1; w_alu_op = ALUOP_FUNCT; end
            LW:     begin w_reg_write_op = 1'b1; ALUSrc = 1'b1; MemToReg = 1'b1; end
            SW:     begin ALUSrc = 1'b1; MemWrite = 1'b1; end
            BEQ:    begin Branch = 1'b1; w_alu_op = ALUOP_SUB; end
            ADDI:   begin w_reg_write_op = 1'b1; ALUSrc = 1'b1; end
            J:      Jump = 1'b1;
            default: ;
        endcase
    end

    // An R-type with an unrecognised funct still computes an add but must not write back.
    always_comb begin
        ALUControl = ALU_ADD;
        w_funct_ok = 1'b1;
        case (w_alu_op)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (w_funct)
                    FUNCT_ADD:      ALUControl = ALU_ADD;
                    FUNCT_SUBTRACT: ALUControl = ALU_SUB;
                    FUNCT_AND:      ALUControl = ALU_AND;
                    FUNCT_OR:       ALUControl = ALU_OR;
                    FUNCT_SLT:      ALUControl = ALU_SLT;
                    default:        w_funct_ok = 1'b0;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    assign RegWrite = w_reg_write_op & w_funct_ok;
    assign w_src_b  = ALUSrc ? SignImm : RD2;

    mips_alu u_alu (
        .i_ctrl   (ALUControl),
        .i_a      (RD1),
        .i_b      (w_src_b),
        .o_result (ALUResult),
        .o_zero   (Zero)
    );

    assign PCSrc = Branch & Zero;
    assign w_idx = ALUResult[ADDR_W-1:0];

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (MemWrite) begin
            r_mem[w_idx] <= RD2;
        end
    end

    assign ReadData = r_mem[w_idx];
    assign Result   = MemToReg ? ReadData : ALUResult;

endmodule

// File: tb/tb_mips_exec_unit.sv
// tb/tb_mips_exec_unit.sv - scoreboard bench for mips_exec_unit
module tb_mips_exec_unit;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] Instr, RD1, RD2;
    logic        Jump, Branch, PCSrc, RegWrite, RegDst, ALUSrc, MemWrite, MemToReg;
    logic [2:0]  ALUControl;
    logic [31:0] SignImm, ALUResult, ReadData, Result;
    logic        Zero;

    mips_exec_unit #(.DEPTH(256), .ADDR_W(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .Instr(Instr), .RD1(RD1), .RD2(RD2),
        .Jump(Jump), .Branch(Branch), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .ALUControl(ALUControl), .SignImm(SignImm), .ALUResult(ALUResult),
        .Zero(Zero), .ReadData(ReadData), .Result(Result)
    );

    always #5 CLOCK = ~CLOCK;

    // ctrl = {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemToReg,Jump,PCSrc,ALUControl[2:0]}
    typedef struct {
        string       name;
        logic [10:0] ctrl;
        logic [31:0] alu;
        logic [31:0] simm;
        logic [31:0] rd;
        logic [31:0] res;
        bit          chk_rd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] r_ins(input logic [5:0] f);
        return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic apply(input string name, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic rst, input logic [10:0] ctrl,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] res,
                         input bit chk_rd);
        exp_t e;
        @(posedge CLOCK);
        #1;
        Instr = ins;
        RD1   = a;
        RD2   = b;
        RESET = rst;
        e.name   = name;
        e.ctrl   = ctrl;
        e.alu    = alu;
        e.simm   = {{16{ins[15]}}, ins[15:0]};
        e.rd     = rd;
        e.res    = res;
        e.chk_rd = chk_rd;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                chk(e.name, "ctrl", {21'd0, RegWrite, RegDst, ALUSrc, Branch, MemWrite,
                                     MemToReg, Jump, PCSrc, ALUControl}, {21'd0, e.ctrl});
                chk(e.name, "ALUResult", ALUResult, e.alu);
                chk(e.name, "Zero", {31'd0, Zero}, {31'd0, e.alu == 32'd0});
                chk(e.name, "SignImm", SignImm, e.simm);
                chk(e.name, "Result", Result, e.res);
                if (e.chk_rd) chk(e.name, "ReadData", ReadData, e.rd);
            end
        end
    end

    initial begin
        RESET = 1'b0;
        Instr = i_ins(6'b111111, 16'h0);
        RD1   = '0;
        RD2   = '0;
        #1 RESET = 1'b1;
        repeat (2) @(posedge CLOCK);

        apply("reset_lw",   i_ins(6'b100011, 16'h0000), 32'd0, 32'd0, 1'b1,
              11'b1010010_0_010, 32'd0, 32'd0, 32'd0, 1);
        apply("add",        r_ins(6'b100000), 32'd5, 32'd5, 1'b0,
              11'b1100000_0_010, 32'd10, 32'd0, 32'd10, 0);
        apply("sub_neg",    r_ins(6'b100010), 32'd5, 32'd7, 1'b0,
              11'b1100000_0_110, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFE, 0);
        apply("sub_zero",   r_ins(6'b100010), 32'd9, 32'd9, 1'b0,
              11'b1100000_0_110, 32'd0, 32'd0, 32'd0, 0);
        apply("slt_true",   r_ins(6'b101010), 32'hFFFFFFFF, 32'd1, 1'b0,
              11'b1100000_0_111, 32'd1, 32'd0, 32'd1, 0);
        apply("slt_false",  r_ins(6'b101010), 32'd1, 32'hFFFFFFFF, 1'b0,
              11'b1100000_0_111, 32'd0, 32'd0, 32'd0, 0);
        apply("and",        r_ins(6'b100100), 32'h0000F0F0, 32'h0000FF00, 1'b0,
              11'b1100000_0_000, 32'h0000F000, 32'd0, 32'h0000F000, 0);
        apply("or",         r_ins(6'b100101), 32'h0000F0F0, 32'h0000FF00, 1'b0,
              11'b1100000_0_001, 32'h0000FFF0, 32'd0, 32'h0000FFF0, 0);
        apply("bad_funct",  r_ins(6'b000111), 32'd3, 32'd4, 1'b0,
              11'b0100000_0_010, 32'd7, 32'd0, 32'd7, 0);
        apply("addi_neg",   i_ins(6'b001000, 16'hFFFF), 32'd5, 32'd0, 1'b0,
              11'b1010000_0_010, 32'd4, 32'd0, 32'd4, 0);
        apply("sw_12",      i_ins(6'b101011, 16'h0008), 32'd4, 32'hDEADBEEF, 1'b0,
              11'b0010100_0_010, 32'd12, 32'd0, 32'd12, 1);
        apply("lw_12",      i_ins(6'b100011, 16'h0008), 32'd4, 32'd0, 1'b0,
              11'b1010010_0_010, 32'd12, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        apply("beq_taken",  i_ins(6'b000100, 16'h0010), 32'd7, 32'd7, 1'b0,
              11'b0001000_1_110, 32'd0, 32'd0, 32'd0, 0);
        apply("beq_not",    i_ins(6'b000100, 16'h0010), 32'd7, 32'd8, 1'b0,
              11'b0001000_0_110, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 0);
        apply("jump",       {6'b000010, 26'h0000040}, 32'd1, 32'd2, 1'b0,
              11'b0000001_0_010, 32'd3, 32'd0, 32'd3, 0);
        apply("noop",       i_ins(6'b111111, 16'h0000), 32'd1, 32'd2, 1'b0,
              11'b0000000_0_010, 32'd3, 32'd0, 32'd3, 0);
        apply("sw_wrap",    i_ins(6'b101011, 16'h0100), 32'd5, 32'h0000A5A5, 1'b0,
              11'b0010100_0_010, 32'h00000105, 32'd0, 32'h00000105, 1);
        apply("lw_wrap",    i_ins(6'b100011, 16'h0005), 32'd0, 32'd0, 1'b0,
              11'b1010010_0_010, 32'd5, 32'h0000A5A5, 32'h0000A5A5, 1);
        apply("sw_3",       i_ins(6'b101011, 16'h0003), 32'd0, 32'h00001234, 1'b0,
              11'b0010100_0_010, 32'd3, 32'd0, 32'd3, 1);
        apply("lw_3",       i_ins(6'b100011, 16'h0003), 32'd0, 32'd0, 1'b0,
              11'b1010010_0_010, 32'd3, 32'h00001234, 32'h00001234, 1);
        apply("lw_3_async", i_ins(6'b100011, 16'h0003), 32'd0, 32'd0, 1'b1,
              11'b1010010_0_010, 32'd3, 32'd0, 32'd0, 1);
        apply("sw_in_rst",  i_ins(6'b101011, 16'h0003), 32'd0, 32'h00005555, 1'b1,
              11'b0010100_0_010, 32'd3, 32'd0, 32'd3, 1);
        apply("lw_after",   i_ins(6'b100011, 16'h0003), 32'd0, 32'd0, 1'b0,
              11'b1010010_0_010, 32'd3, 32'd0, 32'd0, 1);

        repeat (3) @(posedge CLOCK);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_exec_unit.md
Name: mips_exec_unit

Overview:
Combined decode/execute/data-memory slice of the single-cycle MIPS core.
- Decodes a 32-bit instruction into datapath control signals.
- Runs the ALU on register operands or the sign-extended immediate.
- Accesses a word-wide data memory and selects the register write-back value.
- PC register, register file and instruction memory are outside this block; it feeds them control, Result and PCSrc.

Parameters:
DEPTH, 256, number of 32-bit data-memory words.
ADDR_W, 8, index width; log2(DEPTH).

Ports:
CLOCK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  asynchronous active-high reset; clears the data memory.
Instr  input  32  current instruction: op=[31:26], funct=[5:0], imm=[15:0].
RD1  input  32  register-file port-1 data (SrcA).
RD2  input  32  register-file port-2 data (SrcB when ALUSrc=0; store data).
Jump  output  1  selects the jump target for the next PC.
Branch  output  1  instruction is BEQ.
PCSrc  output  1  Branch AND Zero.
RegWrite  output  1  register-file write enable.
RegDst  output  1  1 = write Instr[15:11], 0 = write Instr[20:16].
ALUSrc  output  1  1 = SrcB is SignImm.
MemWrite  output  1  data-memory write enable.
MemToReg  output  1  1 = Result is ReadData.
ALUControl  output  3  ALU operation code.
SignImm  output  32  Instr[15:0] sign-extended.
ALUResult  output  32  ALU output; also the memory address.
Zero  output  1  ALUResult == 0.
ReadData  output  32  data-memory read data.
Result  output  32  write-back value.

Behaviour:
- All outputs except memory contents are purely combinational; zero-cycle latency.
- Opcode decode (RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemToReg, Jump, ALUOp):
  - R-type 000000: 1,1,0,0,0,0,0,ALUOp=10.
  - LW 100011: 1,0,1,0,0,1,0,00.
  - SW 101011: 0,0,1,0,1,0,0,00.
  - BEQ 000100: 0,0,0,1,0,0,0,01.
  - ADDI 001000: 1,0,1,0,0,0,0,00.
  - J 000010: 0,0,0,0,0,0,1,00.
  - Any other opcode (including NOOP 111111): all enables 0, ALUControl=010. Never writes state.
- ALUControl derivation:
  - ALUOp 00 -> 010.
  - ALUOp 01 -> 110.
  - ALUOp 10 by funct: 100000 ADD->010; 100010 SUB->110; 100100 AND->000; 100101 OR->001; 101010 SLT->111.
  - Unknown funct -> 010 and RegWrite forced 0.
- ALU, with B = ALUSrc ? SignImm : RD2:
  - 000 A&B; 001 A|B; 010 A+B; 100 A&~B; 101 A|~B; 110 A-B.
  - 111 = 1 if A<B as signed, else 0.
  - 011 -> 0.
  - Add/sub are modulo 2^32; overflow ignored.
- Zero = (ALUResult == 0). PCSrc = Branch & Zero.
- Data memory:
  - Index = ALUResult[ADDR_W-1:0]; one 32-bit word per index, i.e. the raw address selects a word.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH.
  - Read is asynchronous: ReadData = mem[index] in the same cycle.
  - Write: on rising CLOCK with MemWrite=1 and RESET=0, mem[index] <= RD2.
  - A read of the address being written returns the old value until the edge.
- Result = MemToReg ? ReadData : ALUResult.
- Reset:
  - While RESET=1, all memory words read 0 and writes are blocked.
  - Assertion mid-cycle clears immediately without waiting for CLOCK.
  - Combinational outputs are unaffected by RESET except ReadData.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: R_TYPE, LW, SW, BEQ, ADDI, J, NOOP;
  - funct constants: FUNCT_ADD, FUNCT_SUBTRACT, FUNCT_AND, FUNCT_OR, FUNCT_SLT;
  - the ALUControl encodings.
- Natural sub-module: mips_alu (pure combinational ALU plus Zero).
- Decoder and memory stay inline.

Test Plan:
1. R-type ADD, funct 100000, RD1=5, RD2=5 -> ALUControl=010, RegWrite=1, RegDst=1, Result=10, Zero=0, MemWrite=0.
2. R-type SUB, RD1=5, RD2=7 -> ALUControl=110, Result=0xFFFFFFFE. Then RD1=RD2=9 -> Result=0, Zero=1.
3. SLT, RD1=0xFFFFFFFF, RD2=1 -> Result=1. Swap operands -> 0.
4. SW, imm=8, RD1=4, RD2=0xDEADBEEF, clock edge; then LW with the same imm and RD1 -> ALUResult=12, ReadData=Result=0xDEADBEEF, MemToReg=1, RegWrite=1.
5. BEQ with RD1=RD2=7 -> Branch=1, Zero=1, PCSrc=1. RD2=8 -> PCSrc=0. J -> Jump=1 with RegWrite=MemWrite=0. NOOP -> all enables 0.
6. Write 0x1234 to address 3, assert RESET asynchronously between edges -> ReadData at address 3 becomes 0 immediately. SW while RESET=1 -> no write.
